rvv_backend_decode_ctrl: RTL and testbench

- Sequences the vector decode unit between the command queue (CQ) and the uop queue (UQ).
- Owns the uop_index_remain register, which tracks the resume point when one instruction splits into more uops than fit per cycle or than the UQ can accept.
- Generates per-slot UQ push strobes and the CQ pop, and handles trap flush.

---
 rtl/rvv_backend_decode_ctrl_pkg.sv | 13 +
 rtl/rvv_backend_decode_push_mask.sv | 31 +++
 rtl/rvv_backend_decode_ctrl.sv | 112 +++++++++++
 tb/tb_rvv_backend_decode_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rvv_backend_decode_ctrl_pkg.sv
// Shared decode-control types and default sizing for the vector backend.
package rvv_backend_decode_ctrl_pkg;

   localparam int unsigned NUM_DE_UOP_DEF      = 4;
   localparam int unsigned UOP_INDEX_WIDTH_DEF = 3;
   localparam int unsigned UQ_FREE_WIDTH_DEF   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } DECODE_CTRL_STATE_e;

endpackage

// File: rtl/rvv_backend_decode_push_mask.sv
// Combinational UQ push mask: pushes the valid slot prefix that fits in the free UQ entries.
module rvv_backend_decode_push_mask
   import rvv_backend_decode_ctrl_pkg::*;
#(
   parameter int unsigned NUM_DE_UOP    = NUM_DE_UOP_DEF,
   parameter int unsigned UQ_FREE_WIDTH = UQ_FREE_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH     = $clog2(NUM_DE_UOP + 1)
) (
   input  logic                     enable,
   input  logic [NUM_DE_UOP-1:0]    de_uop_valid,
   input  logic [NUM_DE_UOP-1:0]    de_uop_last,
   input  logic [UQ_FREE_WIDTH-1:0] uq_free_cnt,
   output logic [NUM_DE_UOP-1:0]    uq_push,
   output logic [CNT_WIDTH-1:0]     n_push,
   output logic                     last_pushed
);

   always_comb begin
      uq_push = '0;
      n_push  = '0;
      for (int unsigned i = 0; i < NUM_DE_UOP; i++) begin
         if (enable && de_uop_valid[i] && (i < 32'(uq_free_cnt))) begin
            uq_push[i] = 1'b1;
         end
         n_push = n_push + CNT_WIDTH'(uq_push[i]);
      end
   end

   assign last_pushed = |(uq_push & de_uop_last);

endmodule

// File: rtl/rvv_backend_decode_ctrl.sv
// Decode sequencing between CQ and UQ; tracks the split-instruction resume index.
// Optional perf counters are enabled with RVV_DECODE_PERF_EN.
module rvv_backend_decode_ctrl
   import rvv_backend_decode_ctrl_pkg::*;
#(
   parameter int unsigned NUM_DE_UOP      = NUM_DE_UOP_DEF,
   parameter int unsigned UOP_INDEX_WIDTH = UOP_INDEX_WIDTH_DEF,
   parameter int unsigned UQ_FREE_WIDTH   = UQ_FREE_WIDTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       trap_flush_rvv,
   input  logic                       inst_valid_cq2de,
   input  logic [NUM_DE_UOP-1:0]      de_uop_valid,
   input  logic [NUM_DE_UOP-1:0]      de_uop_last,
   input  logic [UQ_FREE_WIDTH-1:0]   uq_free_cnt,
   output logic [UOP_INDEX_WIDTH-1:0] uop_index_remain,
   output logic [NUM_DE_UOP-1:0]      uq_push,
   output logic                       pop_de2cq
`ifdef RVV_DECODE_PERF_EN
   ,
   output logic [31:0]                perf_uq_stall_cnt,
   output logic [31:0]                perf_split_cnt
`endif
);

   localparam int unsigned CNT_WIDTH = $clog2(NUM_DE_UOP + 1);

   DECODE_CTRL_STATE_e         state, state_next;
   logic [UOP_INDEX_WIDTH-1:0] index_next;
   logic [UOP_INDEX_WIDTH:0]   index_sum;
   logic [CNT_WIDTH-1:0]       n_push;
   logic                       last_pushed;
   logic                       enable;
   logic                       discard;

   assign enable  = inst_valid_cq2de & ~trap_flush_rvv & ~rst;
   // Instruction with no decodable uops is retired silently.
   assign discard = enable & ~(|de_uop_valid);

   rvv_backend_decode_push_mask #(
      .NUM_DE_UOP    (NUM_DE_UOP),
      .UQ_FREE_WIDTH (UQ_FREE_WIDTH),
      .CNT_WIDTH     (CNT_WIDTH)
   ) u_push_mask (
      .enable       (enable),
      .de_uop_valid (de_uop_valid),
      .de_uop_last  (de_uop_last),
      .uq_free_cnt  (uq_free_cnt),
      .uq_push      (uq_push),
      .n_push       (n_push),
      .last_pushed  (last_pushed)
   );

   assign pop_de2cq = last_pushed | discard;
   assign index_sum = {1'b0, uop_index_remain} + (UOP_INDEX_WIDTH + 1)'(n_push);

   always_comb begin
      state_next = state;
      index_next = uop_index_remain;
      if (trap_flush_rvv || pop_de2cq) begin
         state_next = IDLE;
         index_next = '0;
      end else if (n_push != '0) begin
         state_next = SPLIT;
         index_next = index_sum[UOP_INDEX_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         uop_index_remain <= '0;
      end else begin
         state            <= state_next;
         uop_index_remain <= index_next;
      end
   end

`ifdef RVV_DECODE_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_uq_stall_cnt <= '0;
         perf_split_cnt    <= '0;
      end else begin
         if (inst_valid_cq2de && (|de_uop_valid) && (n_push == '0) && !trap_flush_rvv &&
             (perf_uq_stall_cnt != '1)) begin
            perf_uq_stall_cnt <= perf_uq_stall_cnt + 32'd1;
         end
         if (state == IDLE && state_next == SPLIT) begin
            perf_split_cnt <= perf_split_cnt + 32'd1;
         end
      end
   end
`endif

`ifdef ASSERT_ON
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert ((de_uop_valid & (de_uop_valid + 1'b1)) == '0)
            else $error("de_uop_valid not contiguous from bit 0");
         assert ($onehot0(de_uop_last) && ((de_uop_last & ~de_uop_valid) == '0))
            else $error("de_uop_last multi-hot or on a non-valid slot");
         assert (!(state == SPLIT && !inst_valid_cq2de && !trap_flush_rvv))
            else $error("inst_valid_cq2de dropped during split without flush");
         assert (!(index_sum[UOP_INDEX_WIDTH] && !last_pushed && !trap_flush_rvv))
            else $error("uop index overflow without last uop");
      end
   end
`endif

endmodule

// File: tb/tb_rvv_backend_decode_ctrl.sv
// Directed self-checking bench for rvv_backend_decode_ctrl (perf checks under RVV_DECODE_PERF_EN).
module tb_rvv_backend_decode_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       trap_flush_rvv;
   logic       inst_valid_cq2de;
   logic [3:0] de_uop_valid;
   logic [3:0] de_uop_last;
   logic [2:0] uq_free_cnt;
   logic [2:0] uop_index_remain;
   logic [3:0] uq_push;
   logic       pop_de2cq;
`ifdef RVV_DECODE_PERF_EN
   logic [31:0] perf_uq_stall_cnt;
   logic [31:0] perf_split_cnt;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rvv_backend_decode_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .trap_flush_rvv   (trap_flush_rvv),
      .inst_valid_cq2de (inst_valid_cq2de),
      .de_uop_valid     (de_uop_valid),
      .de_uop_last      (de_uop_last),
      .uq_free_cnt      (uq_free_cnt),
      .uop_index_remain (uop_index_remain),
      .uq_push          (uq_push),
      .pop_de2cq        (pop_de2cq)
`ifdef RVV_DECODE_PERF_EN
      ,
      .perf_uq_stall_cnt (perf_uq_stall_cnt),
      .perf_split_cnt    (perf_split_cnt)
`endif
   );

   // Inputs change on the falling edge; outputs are sampled 1ns later.
   task automatic drive(input logic r, input logic iv, input logic [3:0] v, input logic [3:0] l,
                        input logic [2:0] f, input logic fl);
      @(negedge clk);
      rst = r; inst_valid_cq2de = iv; de_uop_valid = v; de_uop_last = l;
      uq_free_cnt = f; trap_flush_rvv = fl;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      drive(1'b1, 1'b1, 4'b1111, 4'b1000, 3'd4, 1'b0);
      tests++; if (uq_push !== 4'b0000) begin fails++; $display("FAIL reset_push: got %b want 0000", uq_push); end
      tests++; if (pop_de2cq !== 1'b0) begin fails++; $display("FAIL reset_pop: got %b want 0", pop_de2cq); end
      tick;
      tests++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL reset_index: got %0d want 0", uop_index_remain); end
      drive(1'b0, 1'b0, 4'b0000, 4'b0000, 3'd4, 1'b0);
      tests++; if (pop_de2cq !== 1'b0) begin fails++; $display("FAIL idle_pop: got %b want 0", pop_de2cq); end
      tick;
   endtask

   task automatic test_single;
      drive(1'b0, 1'b1, 4'b0011, 4'b0010, 3'd4, 1'b0);
      tests++; if (uq_push !== 4'b0011) begin fails++; $display("FAIL single_push: got %b want 0011", uq_push); end
      tests++; if (pop_de2cq !== 1'b1) begin fails++; $display("FAIL single_pop: got %b want 1", pop_de2cq); end
      tick;
      tests++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL single_index: got %0d want 0", uop_index_remain); end
   endtask

   task automatic test_split;
      drive(1'b0, 1'b1, 4'b1111, 4'b0000, 3'd4, 1'b0);
      tests++; if (uq_push !== 4'b1111) begin fails++; $display("FAIL split0_push: got %b want 1111", uq_push); end
      tests++; if (pop_de2cq !== 1'b0) begin fails++; $display("FAIL split0_pop: got %b want 0", pop_de2cq); end
      tick;
      tests++; if (uop_index_remain !== 3'd4) begin fails++; $display("FAIL split0_index: got %0d want 4", uop_index_remain); end
      drive(1'b0, 1'b1, 4'b0011, 4'b0010, 3'd4, 1'b0);
      tests++; if (uq_push !== 4'b0011) begin fails++; $display("FAIL split1_push: got %b want 0011", uq_push); end
      tests++; if (pop_de2cq !== 1'b1) begin fails++; $display("FAIL split1_pop: got %b want 1", pop_de2cq); end
      tick;
      tests++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL split1_index: got %0d want 0", uop_index_remain); end
   endtask

   task automatic test_backpressure;
      drive(1'b0, 1'b1, 4'b1111, 4'b1000, 3'd2, 1'b0);
      tests++; if (uq_push !== 4'b0011) begin fails++; $display("FAIL bp_push: got %b want 0011", uq_push); end
      tests++; if (pop_de2cq !== 1'b0) begin fails++; $display("FAIL bp_pop: got %b want 0", pop_de2cq); end
      tick;
      tests++; if (uop_index_remain !== 3'd2) begin fails++; $display("FAIL bp_index: got %0d want 2", uop_index_remain); end
      drive(1'b0, 1'b1, 4'b1111, 4'b1000, 3'd0, 1'b0);
      tests++; if (uq_push !== 4'b0000) begin fails++; $display("FAIL bp_free0_push: got %b want 0000", uq_push); end
      tests++; if (pop_de2cq !== 1'b0) begin fails++; $display("FAIL bp_free0_pop: got %b want 0", pop_de2cq); end
      tick;
      tests++; if (uop_index_remain !== 3'd2) begin fails++; $display("FAIL bp_free0_index: got %0d want 2", uop_index_remain); end
      drive(1'b0, 1'b1, 4'b0011, 4'b0010, 3'd4, 1'b0);
      tests++; if (pop_de2cq !== 1'b1) begin fails++; $display("FAIL bp_tail_pop: got %b want 1", pop_de2cq); end
      tick;
      tests++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL bp_tail_index: got %0d want 0", uop_index_remain); end
   endtask

   task automatic test_discard;
      drive(1'b0, 1'b1, 4'b0000, 4'b0000, 3'd0, 1'b0);
      tests++; if (uq_push !== 4'b0000) begin fails++; $display("FAIL discard_push: got %b want 0000", uq_push); end
      tests++; if (pop_de2cq !== 1'b1) begin fails++; $display("FAIL discard_pop: got %b want 1", pop_de2cq); end
      tick;
      tests++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL discard_index: got %0d want 0", uop_index_remain); end
   endtask

   task automatic test_flush;
      drive(1'b0, 1'b1, 4'b1111, 4'b0000, 3'd4, 1'b0);
      tick;
      tests++; if (uop_index_remain !== 3'd4) begin fails++; $display("FAIL flush_pre_index: got %0d want 4", uop_index_remain); end
      drive(1'b0, 1'b1, 4'b0011, 4'b0010, 3'd4, 1'b1);
      tests++; if (uq_push !== 4'b0000) begin fails++; $display("FAIL flush_push: got %b want 0000", uq_push); end
      tests++; if (pop_de2cq !== 1'b0) begin fails++; $display("FAIL flush_pop: got %b want 0", pop_de2cq); end
      tick;
      tests++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL flush_index: got %0d want 0", uop_index_remain); end
      drive(1'b0, 1'b1, 4'b1111, 4'b0000, 3'd4, 1'b0);
      tick;
      tests++; if (uop_index_remain !== 3'd4) begin fails++; $display("FAIL rst_pre_index: got %0d want 4", uop_index_remain); end
      drive(1'b1, 1'b1, 4'b0011, 4'b0010, 3'd4, 1'b0);
      tests++; if (uq_push !== 4'b0000) begin fails++; $display("FAIL rst_split_push: got %b want 0000", uq_push); end
      tests++; if (pop_de2cq !== 1'b0) begin fails++; $display("FAIL rst_split_pop: got %b want 0", pop_de2cq); end
      tick;
      tests++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL rst_split_index: got %0d want 0", uop_index_remain); end
      drive(1'b0, 1'b0, 4'b0000, 4'b0000, 3'd4, 1'b0);
      tick;
   endtask

   task automatic test_free_limits;
      drive(1'b0, 1'b1, 4'b0111, 4'b0100, 3'd7, 1'b0);
      tests++; if (uq_push !== 4'b0111) begin fails++; $display("FAIL free7_push: got %b want 0111", uq_push); end
      tests++; if (pop_de2cq !== 1'b1) begin fails++; $display("FAIL free7_pop: got %b want 1", pop_de2cq); end
      tick;
      drive(1'b0, 1'b1, 4'b1111, 4'b0100, 3'd3, 1'b0);
      tests++; if (uq_push !== 4'b0111) begin fails++; $display("FAIL free3_push: got %b want 0111", uq_push); end
      tests++; if (pop_de2cq !== 1'b1) begin fails++; $display("FAIL free3_pop: got %b want 1", pop_de2cq); end
      tick;
      tests++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL free3_index: got %0d want 0", uop_index_remain); end
   endtask

   task automatic test_back_to_back;
      drive(1'b0, 1'b1, 4'b1111, 4'b1000, 3'd4, 1'b0);
      tests++; if (pop_de2cq !== 1'b1) begin fails++; $display("FAIL b2b_a_pop: got %b want 1", pop_de2cq); end
      tick;
      drive(1'b0, 1'b1, 4'b0001, 4'b0001, 3'd4, 1'b0);
      tests++; if (uq_push !== 4'b0001) begin fails++; $display("FAIL b2b_b_push: got %b want 0001", uq_push); end
      tests++; if (pop_de2cq !== 1'b1) begin fails++; $display("FAIL b2b_b_pop: got %b want 1", pop_de2cq); end
      tick;
      tests++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL b2b_index: got %0d want 0", uop_index_remain); end
      drive(1'b0, 1'b0, 4'b0001, 4'b0001, 3'd4, 1'b0);
      tests++; if (uq_push !== 4'b0000) begin fails++; $display("FAIL noinst_push: got %b want 0000", uq_push); end
      tests++; if (pop_de2cq !== 1'b0) begin fails++; $display("FAIL noinst_pop: got %b want 0", pop_de2cq); end
      tick;
   endtask

`ifdef RVV_DECODE_PERF_EN
   task automatic test_perf;
      drive(1'b1, 1'b0, 4'b0000, 4'b0000, 3'd4, 1'b0);
      tick;
      tests++; if (perf_uq_stall_cnt !== 32'd0) begin fails++; $display("FAIL perf_stall_rst: got %0d want 0", perf_uq_stall_cnt); end
      tests++; if (perf_split_cnt !== 32'd0) begin fails++; $display("FAIL perf_split_rst: got %0d want 0", perf_split_cnt); end
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 4'b0011, 4'b0010, 3'd0, 1'b0);
         tick;
      end
      tests++; if (perf_uq_stall_cnt !== 32'd3) begin fails++; $display("FAIL perf_stall_cnt: got %0d want 3", perf_uq_stall_cnt); end
      drive(1'b0, 1'b1, 4'b0011, 4'b0010, 3'd4, 1'b0);
      tick;
      drive(1'b0, 1'b1, 4'b1111, 4'b0000, 3'd4, 1'b0);
      tick;
      drive(1'b0, 1'b1, 4'b0011, 4'b0010, 3'd4, 1'b0);
      tick;
      tests++; if (perf_split_cnt !== 32'd1) begin fails++; $display("FAIL perf_split_cnt: got %0d want 1", perf_split_cnt); end
      tests++; if (perf_uq_stall_cnt !== 32'd3) begin fails++; $display("FAIL perf_stall_hold: got %0d want 3", perf_uq_stall_cnt); end
      drive(1'b0, 1'b0, 4'b0000, 4'b0000, 3'd4, 1'b0);
      tick;
   endtask
`endif

   initial begin
      rst = 1'b1; trap_flush_rvv = 1'b0; inst_valid_cq2de = 1'b0;
      de_uop_valid = '0; de_uop_last = '0; uq_free_cnt = '0;
      test_reset;
      test_single;
      test_split;
      test_backpressure;
      test_discard;
      test_flush;
      test_free_limits;
      test_back_to_back;
`ifdef RVV_DECODE_PERF_EN
      test_perf;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
